// File: rtl/seq_ripple_adder.sv
// Multi-cycle ripple-carry adder: WIDTH-bit operands summed CHUNK bits per clock, LSB chunk first.
// Define SEQ_ADDER_SUB_EN to add the `sub` port (a-b via inverted b and carry-in of 1).
module seq_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // RUN   | one chunk added per edge, N edges
  // DONE  | result held until out_ready
  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, carry_out_q, out_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CHUNK:0]   chunk_sum;
  logic             accept, sub_in;

`ifdef SEQ_ADDER_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;

  assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= sub_in ? ~b : b;
            carry_q <= sub_in;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          // Chunk result enters at the MSB end so after N steps the LSB chunk sits at bit 0.
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          sum_q   <= (sum_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
          carry_q <= chunk_sum[CHUNK];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            carry_out_q <= chunk_sum[CHUNK];
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ripple_adder.sv
// Bench for seq_ripple_adder: three instances (CHUNK=1,4,16, WIDTH=16) with a shared scoreboard.
// Define SEQ_ADDER_SUB_EN to also exercise subtraction.
module tb_seq_ripple_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_s  [3];
  logic        in_ready_s  [3];
  logic [15:0] a_s         [3];
  logic [15:0] b_s         [3];
  logic        sub_s       [3];
  logic        out_valid_s [3];
  logic        out_ready_s [3];
  logic [15:0] sum_s       [3];
  logic        carry_s     [3];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [16:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int CH = (k == 0) ? 1 : ((k == 1) ? 4 : 16);
    seq_ripple_adder #(.WIDTH(16), .CHUNK(CH)) u_dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid_s[k]),
      .in_ready(in_ready_s[k]),
      .a(a_s[k]),
      .b(b_s[k]),
`ifdef SEQ_ADDER_SUB_EN
      .sub(sub_s[k]),
`endif
      .out_valid(out_valid_s[k]),
      .out_ready(out_ready_s[k]),
      .sum(sum_s[k]),
      .carry_out(carry_s[k])
    );
  end

  // Presents operands until accepted; on acceptance pushes the arithmetic expectation.
  task automatic issue(input int k, input logic [15:0] av, input logic [15:0] bv,
                       input logic sv, output bit ok);
    logic [16:0] e;
    in_valid_s[k] = 1'b1; a_s[k] = av; b_s[k] = bv; sub_s[k] = sv;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready_s[k]) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin in_valid_s[k] = 1'b0; return; end
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid_s[k] = 1'b0;
    e = sv ? ({1'b0, av} + {1'b0, ~bv} + 17'd1) : ({1'b0, av} + {1'b0, bv});
    sb.push_back(e);
  endtask

  task automatic wait_out(input int k, output int lat, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid_s[k]) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    lat = cyc - acc_cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b0; a_s[k] = '0; b_s[k] = '0; sub_s[k] = 1'b0;
    end
    repeat (3) @(posedge clk); #1;
    tests++;
    if (in_ready_s[1] !== 1'b0) begin fails++; $display("FAIL reset_in_ready_in_rst got=%b exp=0", in_ready_s[1]); end
    rst = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({in_ready_s[k], out_valid_s[k], carry_s[k], sum_s[k]} !== {3'b100, 16'h0000}) begin
        fails++;
        $display("FAIL reset_state[%0d] got rdy=%b vld=%b c=%b sum=%h exp rdy=1 vld=0 c=0 sum=0000",
                 k, in_ready_s[k], out_valid_s[k], carry_s[k], sum_s[k]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok; logic [16:0] e; int lat = 0; bit rdy_bad = 1'b0;
    issue(1, 16'h1234, 16'h4321, 1'b0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_accept timeout"); return; end
    for (int i = 0; i < 20 && !out_valid_s[1]; i++) begin
      if (in_ready_s[1] !== 1'b0) rdy_bad = 1'b1;
      @(posedge clk); #1;
    end
    lat = cyc - acc_cyc;
    if (in_ready_s[1] !== 1'b0) rdy_bad = 1'b1;
    tests++;
    if (rdy_bad) begin fails++; $display("FAIL basic_in_ready_busy got=1 exp=0"); end
    tests++;
    if (out_valid_s[1] !== 1'b1 || lat != 4) begin
      fails++; $display("FAIL basic_latency got vld=%b lat=%0d exp vld=1 lat=4", out_valid_s[1], lat);
    end
    e = sb.pop_front();
    tests++;
    if ({carry_s[1], sum_s[1]} !== e || e !== 17'h05555) begin
      fails++; $display("FAIL basic_sum got=%h exp=%h", {carry_s[1], sum_s[1]}, 17'h05555);
    end
    out_ready_s[1] = 1'b1; @(posedge clk); #1; out_ready_s[1] = 1'b0;
    tests++;
    if (out_valid_s[1] !== 1'b0) begin fails++; $display("FAIL basic_handoff got vld=%b exp=0", out_valid_s[1]); end
  endtask

  task automatic test_carry_ripple();
    bit ok; int lat; logic [16:0] e;
    issue(1, 16'hFFFF, 16'h0001, 1'b0, ok);
    wait_out(1, lat, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL ripple_out timeout"); return; end
    e = sb.pop_front();
    tests++;
    if ({carry_s[1], sum_s[1]} !== 17'h10000 || e !== 17'h10000) begin
      fails++; $display("FAIL ripple_sum got=%h exp=10000", {carry_s[1], sum_s[1]});
    end
    out_ready_s[1] = 1'b1; @(posedge clk); #1; out_ready_s[1] = 1'b0;
  endtask

  task automatic test_hold();
    bit ok; int lat; logic [16:0] e; bit bad = 1'b0;
    issue(1, 16'hABCD, 16'h1111, 1'b0, ok);
    wait_out(1, lat, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL hold_out timeout"); return; end
    e = sb.pop_front();
    // Operands offered while busy must be ignored.
    in_valid_s[1] = 1'b1; a_s[1] = 16'h0000; b_s[1] = 16'h0000;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid_s[1] !== 1'b1 || {carry_s[1], sum_s[1]} !== e || in_ready_s[1] !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad || e !== 17'h0BCDE) begin
      fails++; $display("FAIL hold_stable got vld=%b res=%h rdy=%b exp vld=1 res=0bcde rdy=0",
                        out_valid_s[1], {carry_s[1], sum_s[1]}, in_ready_s[1]);
    end
    out_ready_s[1] = 1'b1; @(posedge clk); #1; out_ready_s[1] = 1'b0; in_valid_s[1] = 1'b0;
    tests++;
    if (out_valid_s[1] !== 1'b0 || in_ready_s[1] !== 1'b1) begin
      fails++; $display("FAIL hold_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid_s[1], in_ready_s[1]);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid_s[1] !== 1'b0 || in_ready_s[1] !== 1'b1 || sum_s[1] !== 16'hBCDE) begin
      fails++; $display("FAIL hold_no_latch got vld=%b rdy=%b sum=%h exp vld=0 rdy=1 sum=bcde",
                        out_valid_s[1], in_ready_s[1], sum_s[1]);
    end
  endtask

  task automatic test_reset_abort();
    bit ok; int lat; logic [16:0] e; bit rose = 1'b0;
    issue(1, 16'h1111, 16'h2222, 1'b0, ok);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      if (out_valid_s[1] !== 1'b0) rose = 1'b1;
      @(posedge clk); #1;
    end
    tests++;
    if (rose) begin fails++; $display("FAIL abort_no_valid got vld=1 exp=0"); end
    issue(1, 16'h00FF, 16'h0001, 1'b0, ok);
    wait_out(1, lat, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL abort_next timeout"); return; end
    e = sb.pop_front();
    tests++;
    if ({carry_s[1], sum_s[1]} !== 17'h00100 || e !== 17'h00100 || lat != 4) begin
      fails++; $display("FAIL abort_next_sum got=%h lat=%0d exp=00100 lat=4", {carry_s[1], sum_s[1]}, lat);
    end
    out_ready_s[1] = 1'b1; @(posedge clk); #1; out_ready_s[1] = 1'b0;
  endtask

`ifdef SEQ_ADDER_SUB_EN
  task automatic test_sub();
    bit ok; int lat; logic [16:0] e;
    issue(1, 16'd7, 16'd5, 1'b1, ok);
    wait_out(1, lat, ok);
    e = sb.pop_front();
    tests++;
    if (!ok || {carry_s[1], sum_s[1]} !== 17'h10002 || e !== 17'h10002) begin
      fails++; $display("FAIL sub_7_5 got=%h exp=10002", {carry_s[1], sum_s[1]});
    end
    out_ready_s[1] = 1'b1; @(posedge clk); #1; out_ready_s[1] = 1'b0;
    issue(1, 16'd5, 16'd7, 1'b1, ok);
    wait_out(1, lat, ok);
    e = sb.pop_front();
    tests++;
    if (!ok || {carry_s[1], sum_s[1]} !== 17'h0FFFE || e !== 17'h0FFFE) begin
      fails++; $display("FAIL sub_5_7 got=%h exp=0fffe", {carry_s[1], sum_s[1]});
    end
    out_ready_s[1] = 1'b1; @(posedge clk); #1; out_ready_s[1] = 1'b0;
  endtask
`endif

  task automatic test_sweep(input int k, input int n);
    bit ok; int lat; logic [16:0] e; logic sv; int d; bit bad;
    for (int op = 0; op < 1000; op++) begin
`ifdef SEQ_ADDER_SUB_EN
      sv = 1'($urandom_range(0, 1));
`else
      sv = 1'b0;
`endif
      out_ready_s[k] = 1'($urandom_range(0, 1));
      issue(k, 16'($urandom), 16'($urandom), sv, ok);
      wait_out(k, lat, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL sweep%0d_timeout op=%0d", n, op); return; end
      e = sb.pop_front();
      tests++;
      if ({carry_s[k], sum_s[k]} !== e || lat != n) begin
        fails++; $display("FAIL sweep%0d_result op=%0d got=%h lat=%0d exp=%h lat=%0d",
                          n, op, {carry_s[k], sum_s[k]}, lat, e, n);
      end
      d = out_ready_s[k] ? 0 : $urandom_range(0, 3);
      bad = 1'b0;
      repeat (d) begin
        @(posedge clk); #1;
        if (out_valid_s[k] !== 1'b1 || {carry_s[k], sum_s[k]} !== e) bad = 1'b1;
      end
      out_ready_s[k] = 1'b1; @(posedge clk); #1; out_ready_s[k] = 1'b0;
      tests++;
      if (bad || out_valid_s[k] !== 1'b0) begin
        fails++; $display("FAIL sweep%0d_handoff op=%0d vld=%b hold_bad=%b exp vld=0 hold_bad=0",
                          n, op, out_valid_s[k], bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_ripple();
    test_hold();
    test_reset_abort();
`ifdef SEQ_ADDER_SUB_EN
    test_sub();
`endif
    test_sweep(0, 16);
    test_sweep(1, 4);
    test_sweep(2, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
